dt_peak_scan: RTL and testbench

Post-processing stage downstream of the distance-transform engine. After the engine finishes, this block performs one raster-order read pass over the 8-bit distance map in the result RAM. It reports the maximum distance, the raster-first coordinate where that maximum occurs, and the count of non-zero (foreground) pixels. It acts as a read-only second master on the result RAM and is started by the engine's completion pulse.

---
 rtl/dt_peak_scan.sv | 114 +++++++++++
 tb/tb_dt_peak_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dt_peak_scan.sv
// Raster read pass over the distance map: reports the peak value, the first location of that peak,
// and the foreground (non-zero) pixel count. Define DT_SCAN_SUM_EN to add the dist_sum accumulator.
module dt_peak_scan #(
    parameter int DIM_LOG2 = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    res_rd,
    output logic [2*DIM_LOG2-1:0]   res_addr,
    input  logic [7:0]              res_di,
    output logic                    done,
    output logic [7:0]              max_val,
    output logic [DIM_LOG2-1:0]     max_x,
    output logic [DIM_LOG2-1:0]     max_y,
    output logic [2*DIM_LOG2:0]     nz_cnt,
`ifdef DT_SCAN_SUM_EN
    output logic [2*DIM_LOG2+7:0]   dist_sum,
`endif
    output logic [1:0]              dbg_state
);

    // Handshake: start is a one-cycle pulse taken only in IDLE. done is a one-cycle pulse,
    // and the results stay stable from done until the next accepted start. There is no
    // backpressure: res_di must be valid in every cycle that res_rd is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        res_rd  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy   = 1'b1;
                res_rd = 1'b1;
                if (res_addr == '1) state_d = ST_FIN;
            end
            ST_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The strict compare keeps the lowest raster address on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_addr <= '0;
            max_val  <= '0;
            max_x    <= '0;
            max_y    <= '0;
            nz_cnt   <= '0;
`ifdef DT_SCAN_SUM_EN
            dist_sum <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    res_addr <= '0;
                    if (start) begin
                        max_val  <= '0;
                        max_x    <= '0;
                        max_y    <= '0;
                        nz_cnt   <= '0;
`ifdef DT_SCAN_SUM_EN
                        dist_sum <= '0;
`endif
                    end
                end
                ST_SCAN: begin
                    // The final increment wraps the address back to zero for the next pass.
                    res_addr <= res_addr + (2*DIM_LOG2)'(1);
                    if (res_di > max_val) begin
                        max_val        <= res_di;
                        {max_y, max_x} <= res_addr;
                    end
                    if (res_di != 8'd0) begin
                        nz_cnt <= nz_cnt + (2*DIM_LOG2+1)'(1);
                    end
`ifdef DT_SCAN_SUM_EN
                    dist_sum <= dist_sum + (2*DIM_LOG2+8)'(res_di);
`endif
                end
                default: begin
                    res_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dt_peak_scan.sv
// Bench for dt_peak_scan on a 64x64 map: a RAM model feeds res_di, and a reference pass over the
// map pushes the expected results into a queue that is checked at each done pulse.
module tb_dt_peak_scan;

  localparam int D   = 6;
  localparam int DIM = 1 << D;
  localparam int N   = 1 << (2 * D);

  logic               clk;
  logic               reset;
  logic               start;
  logic               busy;
  logic               res_rd;
  logic [2*D-1:0]     res_addr;
  logic [7:0]         res_di;
  logic               done;
  logic [7:0]         max_val;
  logic [D-1:0]       max_x;
  logic [D-1:0]       max_y;
  logic [2*D:0]       nz_cnt;
`ifdef DT_SCAN_SUM_EN
  logic [2*D+7:0]     dist_sum;
`endif
  logic [1:0]         dbg_state;

  logic [7:0] mem [N];
  logic [63:0] exp_q[$];
  int total;
  int bad;

  assign res_di = mem[res_addr];

  dt_peak_scan #(.DIM_LOG2(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .done      (done),
    .max_val   (max_val),
    .max_x     (max_x),
    .max_y     (max_y),
    .nz_cnt    (nz_cnt),
`ifdef DT_SCAN_SUM_EN
    .dist_sum  (dist_sum),
`endif
    .dbg_state (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model();
    logic [7:0] mv;
    int pos;
    int nz;
    int sum;
    mv = 8'd0;
    pos = 0;
    nz = 0;
    sum = 0;
    for (int a = 0; a < N; a++) begin
      if (mem[a] > mv) begin
        mv = mem[a];
        pos = a;
      end
      if (mem[a] != 8'd0) nz++;
      sum += int'(mem[a]);
    end
    return {sum[23:0], nz[15:0], 8'(pos / DIM), 8'(pos % DIM), mv};
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < N; a++) mem[a] = v;
  endtask

  task automatic fill_rand(input int hi);
    for (int a = 0; a < N; a++) mem[a] = 8'($urandom_range(0, hi));
  endtask

  task automatic set_px(input int y, input int x, input logic [7:0] v);
    mem[y * DIM + x] = v;
  endtask

  task automatic check_results(input logic [63:0] e);
    check("max_val", 32'(max_val), 32'(e[7:0]));
    check("max_x", 32'(max_x), 32'(e[15:8]));
    check("max_y", 32'(max_y), 32'(e[23:16]));
    check("nz_cnt", 32'(nz_cnt), 32'(e[39:24]));
`ifdef DT_SCAN_SUM_EN
    check("dist_sum", 32'(dist_sum), 32'(e[63:40]));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rd"}, 32'(res_rd), 0);
    check({tag, "_addr"}, 32'(res_addr), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_max_val"}, 32'(max_val), 0);
    check({tag, "_max_x"}, 32'(max_x), 0);
    check({tag, "_max_y"}, 32'(max_y), 0);
    check({tag, "_nz"}, 32'(nz_cnt), 0);
`ifdef DT_SCAN_SUM_EN
    check({tag, "_sum"}, 32'(dist_sum), 0);
`endif
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // driver: one full scan; restart_at pulses a stray start, reset_at aborts with reset
  task automatic run_scan(input int restart_at, input int reset_at);
    int cyc;
    int sweep_bad;
    int late_done;
    bit got_done;
    logic [63:0] e;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_addr", 32'(res_addr), 0);
    exp_q.push_back(model());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("clear_nz", 32'(nz_cnt), 0);
    check("clear_max", 32'(max_val), 0);
    sweep_bad = 0;
    got_done = 1'b0;
    while (cyc <= N + 9) begin
      if (cyc <= N) begin
        if (!res_rd || !busy || (32'(res_addr) != 32'(cyc - 1))) sweep_bad++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (cyc == reset_at) begin
        reset = 1'b1;
        break;
      end
      if (cyc == restart_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("sweep", 32'(sweep_bad), 0);
    if (reset_at != 0) begin
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("abort");
      late_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) late_done++;
      end
      check("abort_quiet", 32'(late_done), 0);
      void'(exp_q.pop_front());
    end else begin
      check("done_seen", 32'(got_done), 1);
      check("latency", 32'(cyc), 32'(N + 1));
      check("fin_rd", 32'(res_rd), 0);
      check("fin_busy", 32'(busy), 1);
      if (got_done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_results(e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    fill(8'd0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    fill(8'd0);
    run_scan(0, 0);

    fill(8'd0);
    set_px(32, 32, 8'd5);
    run_scan(0, 0);

    fill(8'd1);
    set_px(3, 10, 8'd9);
    set_px(50, 2, 8'd9);
    run_scan(0, 0);

    fill(8'd255);
    run_scan(0, 0);

    fill_rand(40);
    run_scan(500, 0);

    fill_rand(3);
    run_scan(0, 0);

    fill_rand(255);
    run_scan(0, 2000);

    fill_rand(100);
    run_scan(0, 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
